screen_fetch_gen: RTL and testbench

- Parametrised successor of the Z88 LCD fetch engine. Walks the Screen Base File, fetches each char's 2-byte attribute and its pixel row from Z88 memory in the Z80-idle clkcnt slots, and packs pixels into 4-bit VRAM nibbles.
- Adds over the previous generation: configurable geometry, correct column/line wrap, per-char effect application before packing (so mixed lores nibbles are correct), flash and grey rendering, end-of-line flush, single-cycle write strobes and a frame marker.
- Sits between the blink register file / memory mux (va, cdi) and the VRAM buffer read by the LCD scanout.

---
 rtl/screen_pkg.sv | 23 ++
 rtl/screen_pixpack.sv | 109 ++++++++++
 rtl/screen_fetch_gen.sv | 205 ++++++++++++++++++++
 tb/tb_screen_fetch_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared types and constants for the LCD screen fetch engine.
// Bus phases follow the blink clkcnt sequence 10 -> 11 -> 00 -> 01.
package screen_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ATTR = 2'd1,
        S_PIX  = 2'd2
    } state_t;

    localparam logic [1:0] PH_Z80  = 2'b10;
    localparam logic [1:0] PH_LO   = 2'b00;
    localparam logic [1:0] PH_HI   = 2'b01;
    localparam logic [1:0] PH_IDLE = 2'b11;

    localparam int A_HRS  = 5;
    localparam int A_REV  = 4;
    localparam int A_FLS  = 3;
    localparam int A_GRY  = 2;
    localparam int A_UND  = 1;
    localparam int A_SBA8 = 0;

endpackage

// File: rtl/screen_pixpack.sv
// Applies per-char effects to a font row and packs it into VRAM nibbles.
// Lores rows may leave 2 pixels held for the next char or a line flush.
module screen_pixpack (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       cap,
    input  logic       hi,
    input  logic       idle,
    input  logic       eol,
    input  logic [7:0] row,
    input  logic       hrs,
    input  logic       rev,
    input  logic       fls,
    input  logic       gry,
    input  logic       und,
    input  logic       ul_line,
    input  logic       flash_ph,
    input  logic       grey_ph,
    output logic       wr,
    output logic       wr_fl,
    output logic [3:0] wr_data
);

    logic [7:0] mask;
    logic [7:0] r;
    logic [1:0] held;
    logic       held_v;
    logic [3:0] pend;
    logic       pend_v;
    logic       fl_pend;

    // Effects run on the full row before packing, so mixed nibbles stay exact.
    always_comb begin
        mask = hrs ? 8'hff : 8'h3f;
        r    = row & mask;
        if (!hrs && und && ul_line)
            r = mask;
        if (fls && flash_ph)
            r = '0;
        if (gry && grey_ph)
            r = '0;
        if (rev)
            r = r ^ mask;
    end

    always_comb begin
        wr      = 1'b0;
        wr_fl   = 1'b0;
        wr_data = '0;
        unique case (1'b1)
            cap: begin
                wr = 1'b1;
                if (hrs)
                    wr_data = r[7:4];
                else if (held_v)
                    wr_data = {held, r[5:4]};
                else
                    wr_data = r[5:2];
            end
            hi && pend_v: begin
                wr      = 1'b1;
                wr_data = pend;
            end
            idle && fl_pend: begin
                wr      = 1'b1;
                wr_fl   = 1'b1;
                wr_data = {held, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held    <= '0;
            held_v  <= 1'b0;
            pend    <= '0;
            pend_v  <= 1'b0;
            fl_pend <= 1'b0;
        end else if (clr) begin
            held    <= '0;
            held_v  <= 1'b0;
            pend    <= '0;
            pend_v  <= 1'b0;
            fl_pend <= 1'b0;
        end else begin
            if (cap) begin
                if (hrs || held_v) begin
                    pend   <= r[3:0];
                    pend_v <= 1'b1;
                end
                if (!hrs) begin
                    held   <= r[1:0];
                    held_v <= !held_v;
                end
            end
            if (hi) begin
                pend_v  <= 1'b0;
                fl_pend <= eol && held_v;
            end
            if (idle && fl_pend) begin
                fl_pend <= 1'b0;
                held_v  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/screen_fetch_gen.sv
// Z88 LCD fetch engine: walks the screen base file, fetches attributes and
// font rows in the idle clkcnt slots and streams 4-bit nibbles into VRAM.
module screen_fetch_gen
    import screen_pkg::*;
#(
    parameter int COLS         = 108,
    parameter int LINES        = 64,
    parameter int VRAM_AW      = 14,
    parameter int FLASH_FRAMES = 32
) (
    input  logic               mck,
    input  logic               rin_n,
    input  logic               lcdon,
    input  logic [1:0]         clkcnt,
    input  logic [7:0]         cdi,
    input  logic [12:0]        pb0,
    input  logic [9:0]         pb1,
    input  logic [8:0]         pb2,
    input  logic [10:0]        pb3,
    input  logic [10:0]        sbr,
    output logic [21:0]        va,
    output logic [VRAM_AW-1:0] vram_a,
    output logic [3:0]         vram_do,
    output logic               vram_we,
    output logic               frame_start
);

    localparam int NW  = VRAM_AW - 6;
    localparam int FCW = $clog2(2 * FLASH_FRAMES);

    state_t state_q;
    state_t state_d;

    logic [6:0]         scol;
    logic [5:0]         slin;
    logic [NW-1:0]      nib;
    logic [VRAM_AW-1:0] fl_a;
    logic [8:0]         sba;
    logic               hrs;
    logic               rev;
    logic               fls;
    logic               gry;
    logic               und;
    logic [FCW-1:0]     fcnt;

    logic        attr_go;
    logic        attr_lo;
    logic        attr_hi;
    logic        attr_idle;
    logic        pix_va;
    logic        pix_cap;
    logic        pix_hi;
    logic        eol;
    logic        lin_wrap;
    logic        flash_ph;
    logic [21:0] attr_va;
    logic [21:0] font_va;

    logic       wr;
    logic       wr_fl;
    logic [3:0] wr_data;

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n)
            state_q <= S_OFF;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!lcdon) begin
            state_d = S_OFF;
        end else begin
            unique case (state_q)
                S_OFF:   if (clkcnt == PH_Z80) state_d = S_ATTR;
                S_ATTR:  if (clkcnt == PH_HI)  state_d = S_PIX;
                S_PIX:   if (clkcnt == PH_HI)  state_d = S_ATTR;
                default: state_d = S_OFF;
            endcase
        end
    end

    // The OFF->ATTR slot already issues the first attribute address.
    always_comb begin
        attr_go   = lcdon && clkcnt == PH_Z80 &&
                    (state_q == S_OFF || state_q == S_ATTR);
        attr_lo   = lcdon && state_q == S_ATTR && clkcnt == PH_LO;
        attr_hi   = lcdon && state_q == S_ATTR && clkcnt == PH_HI;
        attr_idle = lcdon && state_q == S_ATTR && clkcnt == PH_IDLE;
        pix_va    = lcdon && state_q == S_PIX && clkcnt == PH_Z80;
        pix_cap   = lcdon && state_q == S_PIX && clkcnt == PH_LO;
        pix_hi    = lcdon && state_q == S_PIX && clkcnt == PH_HI;
        eol       = scol == 7'(COLS - 1);
        lin_wrap  = slin == 6'(LINES - 1);
        flash_ph  = fcnt >= FCW'(FLASH_FRAMES);
        attr_va   = {sbr, slin[5:3], scol, 1'b0};
        font_va   = '0;
        unique case (1'b1)
            !hrs && sba[8:6] == 3'b111:
                font_va = {pb0, sba[5:0], slin[2:0]};
            !hrs && sba[8:6] != 3'b111:
                font_va = {pb1, sba, slin[2:0]};
            hrs && und && sba[8]:
                font_va = {pb3, sba[7:0], slin[2:0]};
            default:
                font_va = {pb2, und, sba, slin[2:0]};
        endcase
    end

    screen_pixpack u_pixpack (
        .clk      (mck),
        .rst_n    (rin_n),
        .clr      (!lcdon),
        .cap      (pix_cap),
        .hi       (pix_hi),
        .idle     (attr_idle),
        .eol      (eol),
        .row      (cdi),
        .hrs      (hrs),
        .rev      (rev),
        .fls      (fls),
        .gry      (gry),
        .und      (und),
        .ul_line  (slin[2:0] == 3'd7),
        .flash_ph (flash_ph),
        .grey_ph  (fcnt[0]),
        .wr       (wr),
        .wr_fl    (wr_fl),
        .wr_data  (wr_data)
    );

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            va          <= '0;
            vram_a      <= '0;
            vram_do     <= '0;
            vram_we     <= 1'b0;
            frame_start <= 1'b0;
            scol        <= '0;
            slin        <= '0;
            nib         <= '0;
            fl_a        <= '0;
            sba         <= '0;
            hrs         <= 1'b0;
            rev         <= 1'b0;
            fls         <= 1'b0;
            gry         <= 1'b0;
            und         <= 1'b0;
            fcnt        <= '0;
        end else if (!lcdon) begin
            scol        <= '0;
            slin        <= '0;
            nib         <= '0;
            vram_a      <= '0;
            vram_we     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vram_we     <= wr;
            frame_start <= attr_go && scol == '0 && slin == '0;
            if (wr) begin
                vram_do <= wr_data;
                vram_a  <= wr_fl ? fl_a : {slin, nib};
            end
            if (wr && !wr_fl)
                nib <= nib + 1'b1;
            if (attr_go)
                va <= attr_va;
            if (attr_lo) begin
                sba[7:0] <= cdi;
                va[0]    <= 1'b1;
            end
            if (attr_hi) begin
                hrs    <= cdi[A_HRS];
                rev    <= cdi[A_REV];
                fls    <= cdi[A_FLS];
                gry    <= cdi[A_GRY];
                und    <= cdi[A_UND];
                sba[8] <= cdi[A_SBA8];
            end
            if (pix_va)
                va <= font_va;
            // Flush address is frozen here; the flush lands in the next 11 slot.
            if (pix_hi) begin
                if (eol) begin
                    fl_a <= {slin, nib + NW'(wr)};
                    scol <= '0;
                    nib  <= '0;
                    if (lin_wrap) begin
                        slin <= '0;
                        if (fcnt == FCW'(2 * FLASH_FRAMES - 1))
                            fcnt <= '0;
                        else
                            fcnt <= fcnt + 1'b1;
                    end else begin
                        slin <= slin + 1'b1;
                    end
                end else begin
                    scol <= scol + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_screen_fetch_gen.sv
// Randomized bench for screen_fetch_gen against a pixel-stream reference model.
module tb_screen_fetch_gen;
    import screen_pkg::*;

    localparam int COLS  = 3;
    localparam int LINES = 8;
    localparam int AW    = 14;
    localparam int FF    = 2;

    logic          mck    = 1'b0;
    logic          rin_n  = 1'b0;
    logic          lcdon  = 1'b0;
    logic [1:0]    clkcnt = PH_IDLE;
    logic [7:0]    cdi    = '0;
    logic [12:0]   pb0;
    logic [9:0]    pb1;
    logic [8:0]    pb2;
    logic [10:0]   pb3;
    logic [10:0]   sbr;
    logic [21:0]   va;
    logic [AW-1:0] vram_a;
    logic [3:0]    vram_do;
    logic          vram_we;
    logic          frame_start;

    screen_fetch_gen #(
        .COLS(COLS), .LINES(LINES), .VRAM_AW(AW), .FLASH_FRAMES(FF)
    ) dut (
        .mck(mck), .rin_n(rin_n), .lcdon(lcdon), .clkcnt(clkcnt),
        .cdi(cdi), .pb0(pb0), .pb1(pb1), .pb2(pb2), .pb3(pb3),
        .sbr(sbr), .va(va), .vram_a(vram_a), .vram_do(vram_do),
        .vram_we(vram_we), .frame_start(frame_start)
    );

    always #5 mck = ~mck;

    typedef struct {
        logic [AW-1:0] a;
        logic [3:0]    d;
    } wr_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  expq[$];
    bit   pq[$];
    int   mcol;
    int   mlin;
    int   mnib;
    int   mfrm;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge mck) begin
        if (vram_we) begin
            if (expq.size() == 0) begin
                chk("unexpected_we", 32'(vram_we), 32'd0);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("wr_addr", 32'(vram_a), 32'(e.a));
                chk("wr_data", 32'(vram_do), 32'(e.d));
            end
        end
    end

    function automatic void push_nib(input logic [3:0] d);
        wr_t e;
        e.a = {6'(mlin), 8'(mnib)};
        e.d = d;
        expq.push_back(e);
        mnib++;
    endfunction

    function automatic void model_clear();
        mcol = 0;
        mlin = 0;
        mnib = 0;
        pq.delete();
    endfunction

    task automatic step(input logic [1:0] ph, input logic [7:0] d);
        clkcnt = ph;
        cdi    = d;
        @(posedge mck);
        #1;
    endtask

    // mode 0: normal char, 1: lcdon dropped at pixel capture, 2: reset there
    task automatic do_char(input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] pix, input int mode);
        logic [21:0] aa;
        logic [21:0] fa;
        logic [8:0]  sba;
        logic [7:0]  m;
        logic [7:0]  r;
        logic [3:0]  d;
        logic [2:0]  row;
        logic        hrs, rev, fls, gry, und;
        row = 3'(mlin % 8);
        aa  = {sbr, 3'(mlin / 8), 7'(mcol), 1'b0};
        step(PH_Z80, 8'($urandom));
        chk("attr_va", 32'(va), 32'(aa));
        chk("frame_start", 32'(frame_start), 32'(mcol == 0 && mlin == 0));
        step(PH_IDLE, 8'($urandom));
        chk("frame_start_pulse", 32'(frame_start), 32'd0);
        step(PH_LO, lo);
        chk("attr_va_hi", 32'(va), 32'(aa | 22'd1));
        step(PH_HI, hi);
        sba = {hi[0], lo};
        hrs = hi[5];
        rev = hi[4];
        fls = hi[3];
        gry = hi[2];
        und = hi[1];
        if (!hrs && sba[8:6] == 3'b111)
            fa = {pb0, sba[5:0], row};
        else if (!hrs)
            fa = {pb1, sba, row};
        else if (und && sba[8])
            fa = {pb3, sba[7:0], row};
        else
            fa = {pb2, und, sba, row};
        step(PH_Z80, 8'($urandom));
        chk("font_va", 32'(va), 32'(fa));
        step(PH_IDLE, 8'($urandom));
        if (mode != 0)
            chk("queue_drained", 32'(expq.size()), 32'd0);
        if (mode == 1) begin
            lcdon = 1'b0;
            step(PH_LO, pix);
            model_clear();
            return;
        end
        if (mode == 2) begin
            step(PH_LO, pix);
            chk("we_before_reset", 32'(vram_we), 32'd1);
            #1 rin_n = 1'b0;
            #1;
            chk("rst_we", 32'(vram_we), 32'd0);
            chk("rst_va", 32'(va), 32'd0);
            chk("rst_vram_a", 32'(vram_a), 32'd0);
            chk("rst_vram_do", 32'(vram_do), 32'd0);
            chk("rst_frame_start", 32'(frame_start), 32'd0);
            @(posedge mck);
            #1 rin_n = 1'b1;
            model_clear();
            mfrm = 0;
            return;
        end
        m = hrs ? 8'hff : 8'h3f;
        r = pix & m;
        if (!hrs && und && row == 3'd7)
            r = m;
        if (fls && ((mfrm / FF) % 2) == 1)
            r = '0;
        if (gry && (mfrm % 2) == 1)
            r = '0;
        if (rev)
            r = ~r & m;
        if (hrs) begin
            push_nib(r[7:4]);
            push_nib(r[3:0]);
        end else begin
            for (int i = 5; i >= 0; i--)
                pq.push_back(r[i]);
            while (pq.size() >= 4) begin
                for (int i = 0; i < 4; i++)
                    d[3-i] = pq.pop_front();
                push_nib(d);
            end
        end
        if (mcol == COLS - 1) begin
            if (pq.size() > 0) begin
                d = '0;
                for (int i = 0; pq.size() > 0; i++)
                    d[3-i] = pq.pop_front();
                push_nib(d);
            end
            mcol = 0;
            mnib = 0;
            if (mlin == LINES - 1) begin
                mlin = 0;
                mfrm++;
            end else begin
                mlin++;
            end
        end else begin
            mcol++;
        end
        step(PH_LO, pix);
        step(PH_HI, 8'($urandom));
    endtask

    initial begin
        logic [1:0] ph;
        pb0 = 13'($urandom);
        pb1 = 10'($urandom);
        pb2 = 9'($urandom);
        pb3 = 11'($urandom);
        sbr = 11'($urandom);
        model_clear();
        mfrm = 0;

        @(posedge mck);
        #1;
        chk("reset_va", 32'(va), 32'd0);
        chk("reset_vram_a", 32'(vram_a), 32'd0);
        chk("reset_vram_do", 32'(vram_do), 32'd0);
        chk("reset_we", 32'(vram_we), 32'd0);
        chk("reset_frame_start", 32'(frame_start), 32'd0);
        rin_n = 1'b1;
        lcdon = 1'b1;

        do_char(8'h41, 8'h20, 8'ha5, 0);
        do_char(8'h12, 8'h00, 8'h2d, 0);
        do_char(8'h12, 8'h00, 8'h33, 0);
        do_char(8'h12, 8'h00, 8'h2d, 0);
        do_char(8'h12, 8'h10, 8'h33, 0);
        do_char(8'h12, 8'h00, 8'h2d, 0);
        for (int i = 0; i < 4 * COLS * LINES; i++)
            do_char(8'hc5, 8'h08, 8'($urandom), 0);
        repeat (150)
            do_char(8'($urandom), 8'($urandom), 8'($urandom), 0);

        do_char(8'($urandom), 8'($urandom), 8'($urandom), 2);
        repeat (30)
            do_char(8'($urandom), 8'($urandom), 8'($urandom), 0);

        do_char(8'($urandom), 8'($urandom), 8'($urandom), 1);
        ph = PH_HI;
        repeat (8) begin
            step(ph, 8'($urandom));
            chk("off_no_we", 32'(vram_we), 32'd0);
            ph = ph + 2'd1;
        end
        lcdon = 1'b1;
        do_char(8'($urandom), 8'($urandom), 8'($urandom), 1);
        repeat (4) begin
            step(ph, 8'($urandom));
            ph = ph + 2'd1;
        end
        chk("final_queue", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
